c5_mac_8bitx2_collector: RTL
============================

// Module: c5_mac_8bitx2_collector
// PURPOSE
//  Output-side companion of the fixed-latency 2x8-bit MAC (cannot stall; ovalid tied 1).
//  Restores a real valid/ready handshake: accepts operand-pair beats from the feeder, tracks them
//  through the MAC latency, accumulates MAC results over one dot product, and queues each finished
//  dot product in a small FIFO for a back-pressuring consumer. Credits prevent FIFO overflow.
// PARAMETERS
//  MAC_LATENCY  3   cycles from operands at MAC inputs to matching value on mac_result (>=1)
//  ACC_W        32  accumulator / output width; mac_result is 32b, sign-extended or truncated to ACC_W
//  FIFO_DEPTH   8   finished-result entries; power of 2, >=2
// PORTS
//  clock       in   1      single clock; also drives the MAC clock0
//  resetn      in   1      asynchronous, active-low reset
//  ivalid      in   1      feeder: operand pair valid this cycle (operands wired straight to MAC)
//  ilast       in   1      feeder: this pair is the last of the dot product; qualified by ivalid
//  oready      out  1      to feeder: beat accepted when ivalid & oready ("issue")
//  mac_result  in   32     MAC result, aligned MAC_LATENCY cycles after issue
//  ovalid      out  1      to consumer: result valid (FIFO non-empty)
//  result      out  ACC_W  to consumer: FIFO head, full dot-product sum
//  iready      in   1      consumer ready; pop when ovalid & iready
// BEHAVIOUR
//  - Reset (async, resetn=0): tag pipe cleared, acc=0, FIFO empty, inflight=0; ovalid=0, result=0,
//    oready=0. oready comes from a flop set 1 on the first clock edge after resetn deasserts.
//  - Tag pipe: MAC_LATENCY-stage shift of {v,last}; stage0 loaded with {issue, ilast&issue}.
//    Tap {tv,tl} is aligned with mac_result. Bubbles (ivalid=0) shift v=0; mac_result ignored when tv=0.
//  - Accumulate: on tv & ~tl: acc <= acc + mac_result. On tv & tl: push acc+mac_result, acc <= 0.
//    Sum modulo 2^ACC_W (wraps, no saturation). Dot product of one pair: push = that product.
//  - Credits: inflight = tl-beats in pipe. oready = out_of_reset & (fifo_count + inflight < FIFO_DEPTH).
//    Applies to all beats (no last/non-last distinction); push can therefore never hit a full FIFO.
//  - FIFO: push/pop same cycle legal at any count (count unchanged; at count 0 push only, no
//    bypass: data appears on ovalid next cycle). ovalid = count!=0; result = head, stable while
//    ovalid & ~iready. Pointers wrap modulo FIFO_DEPTH.
//  - Latency: last issue at cycle t -> pushed at edge t+MAC_LATENCY -> ovalid at t+MAC_LATENCY+1.
//  - Throughput: 1 beat/cycle while credits remain; consumer stall fills FIFO then drops oready.
//  - ilast with ivalid=0 is ignored. Reset mid-dot-product discards partial acc and in-flight
//    beats; no result is emitted for them.
//  - Assertions (sim): FIFO push when full, pop when empty, inflight underflow -> $error.
// STRUCTURE
//  - Shared package mac_collector_pkg: MAC_LATENCY default, ACC_W default, acc_t typedef,
//    function clog2-based count width.
//  - One sub-module: mac_result_fifo (sync FIFO, DEPTH/WIDTH params, count output, async reset).
//  - Top holds tag pipe, accumulator, credit logic, out_of_reset flop.
// TESTING
//  1 Reset: resetn=0 mid-traffic -> ovalid=0, oready=0 immediately; first edge after release
//    -> oready=1, FIFO empty, acc=0.
//  2 Single dot product: 4 beats mac_result 10,20,-5,7 (last on 4th), iready=1 -> one result 32,
//    ovalid exactly MAC_LATENCY+1 cycles after last issue, single cycle.
//  3 Back-pressure: iready=0, 1-beat dot products streamed -> exactly 8 results held, oready=0
//    once count+inflight=8; iready=1 -> results drain in order, oready returns, none lost/duplicated.
//  4 Bubbles: ivalid toggling 1,0,0,1,1(last) with garbage mac_result during bubbles -> sum only
//    of valid-aligned values.
//  5 Wrap: acc 0x7FFF_FFFF + 1 -> result 0x8000_0000; pointer wrap after 20 push/pop pairs with
//    simultaneous push & pop at count 1 -> count stays 1, order preserved.
//  6 Random: constrained-random lengths 1..64, random iready -> scoreboard vs reference model.

Source files
------------

// File: rtl/c5_mac_8bitx2_collector_pkg.sv
// mac_collector_pkg: shared defaults, accumulator type and counter-width helper
// for the 2x8-bit MAC output collector.
package mac_collector_pkg;

  localparam int MAC_LATENCY_DEF = 3;
  localparam int ACC_W_DEF       = 32;
  localparam int FIFO_DEPTH_DEF  = 8;

  typedef logic [ACC_W_DEF-1:0] acc_t;

  // Width of a counter that must represent every value 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/c5_mac_8bitx2_collector_fifo.sv
// mac_result_fifo: small synchronous FIFO holding finished dot-product sums.
// No bypass: a pushed word becomes visible on the cycle after the push.
// Simultaneous push and pop are legal at any occupancy.
module mac_result_fifo
  import mac_collector_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = ACC_W_DEF,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Head is forced to zero while empty so the consumer never sees stale data.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  a_no_push_full: assert property (@(posedge clock) disable iff (!resetn)
    !(push && full && !pop))
    else $error("mac_result_fifo: push while full");

  a_no_pop_empty: assert property (@(posedge clock) disable iff (!resetn)
    !(pop && empty))
    else $error("mac_result_fifo: pop while empty");

endmodule

// File: rtl/c5_mac_8bitx2_collector.sv
// c5_mac_8bitx2_collector: output-side companion of the fixed-latency 2x8-bit MAC.
// Tracks issued operand beats through the MAC latency with a {valid,last} tag
// pipe, accumulates aligned MAC results per dot product, and queues finished
// sums for a back-pressuring consumer. The feeder is throttled by credits so a
// push can never meet a full FIFO: every dot-product end already in the tag
// pipe has a FIFO slot reserved for it.
module c5_mac_8bitx2_collector
  import mac_collector_pkg::*;
#(
  parameter int MAC_LATENCY = MAC_LATENCY_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ivalid,
  input  logic             ilast,
  output logic             oready,
  input  logic [31:0]      mac_result,
  output logic             ovalid,
  output logic [ACC_W-1:0] result,
  input  logic             iready
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int IW = cnt_w(MAC_LATENCY);

  logic                   out_of_reset;
  logic                   issue;
  logic [MAC_LATENCY-1:0] tag_v;
  logic [MAC_LATENCY-1:0] tag_l;
  logic                   tv;
  logic                   tl;
  logic [IW-1:0]          inflight;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       mac_ext;
  logic [ACC_W-1:0]       acc_sum;
  logic                   push;
  logic                   pop;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   credit_ok;

  assign issue = ivalid & oready;
  assign tv    = tag_v[MAC_LATENCY-1];
  assign tl    = tag_l[MAC_LATENCY-1];

  // The MAC output is signed; widen with sign extension or truncate to ACC_W.
  assign mac_ext = ACC_W'($signed(mac_result));
  assign acc_sum = acc + mac_ext;

  assign push = tv & tl;
  assign pop  = ovalid & iready;

  // Credits cover the FIFO contents plus every dot-product end still in the MAC.
  assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign oready    = out_of_reset & credit_ok;
  assign ovalid    = ~fifo_empty;

  // Holds oready low until the first clock edge after reset release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) out_of_reset <= 1'b0;
    else         out_of_reset <= 1'b1;
  end

  // Tag pipe: stage 0 captures the issued beat, the last stage lines up with mac_result.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= issue;
      tag_l[0] <= issue & ilast;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  // Count of dot-product ends travelling through the MAC.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      inflight <= '0;
    end else begin
      case ({issue & ilast, push})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Running dot-product sum, modulo 2^ACC_W; cleared as the finished sum is pushed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
    end else if (tv) begin
      acc <= tl ? '0 : acc_sum;
    end
  end

  mac_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ACC_W)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .wdata  (acc_sum),
    .pop    (pop),
    .rdata  (result),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  a_inflight_underflow: assert property (@(posedge clock) disable iff (!resetn)
    !(push && inflight == '0))
    else $error("c5_mac_8bitx2_collector: inflight underflow");

  a_credit_push_full: assert property (@(posedge clock) disable iff (!resetn)
    !(push && fifo_full && !pop))
    else $error("c5_mac_8bitx2_collector: result push into full FIFO");

endmodule
